mem_row_fetcher: RTL

MEM_ROW_FETCHER -- requirements
Module: mem_row_fetcher

---
 rtl/mem_row_fetcher.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mem_row_fetcher.sv
// Fetches one memory row per video line into a line buffer, then decodes the buffered
// words into per-pixel binary bit cells or hex digit cells for the display path.
module mem_row_fetcher #(
    parameter int unsigned RAM_WIDTH               = 16,
    parameter int unsigned ADDR_WIDTH              = 8,
    parameter int unsigned WORDS_PER_ROW           = 4,
    parameter int unsigned ROWS                    = 12,
    parameter int unsigned RAM_SCREEN_OFFSET       = 0,
    parameter int unsigned RAM_LATENCY             = 1,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_X = 4,
    parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = 5,
    parameter int unsigned PIXELS_PER_HEX_DIGIT    = 16
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic                  line_start,
    input  logic [9:0]            fetch_y,
    input  logic [9:0]            pixel_x,
    input  logic                  display_en,
    input  logic                  mode,
    output logic [ADDR_WIDTH-1:0] addr_screen,
    input  logic [RAM_WIDTH-1:0]  rdata_screen,
    output logic                  fetch_busy,
    output logic                  cell_valid,
    output logic                  cell_bit,
    output logic [3:0]            cell_nibble,
    output logic                  cell_is_hex,
    output logic                  overrun
);

    localparam int unsigned NIBS_PER_WORD = RAM_WIDTH / 4;
    localparam int unsigned IDX_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS_PER_ROW - 1);
    localparam logic [1:0]       LAST_DRAIN = 2'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;
    logic                  row_valid_q;
    logic                  mode_smp_q;
    logic                  hex_q;
    logic                  overrun_q;
    logic [IDX_W-1:0]      idx_q;
    logic [1:0]            drain_q;
    logic [RAM_LATENCY-1:0] pend_q;
    logic [IDX_W-1:0]      pend_idx_q [RAM_LATENCY];
    logic [RAM_WIDTH-1:0]  line_q [WORDS_PER_ROW];

    logic [9:0]            new_row;
    logic                  new_row_ok;
    logic [ADDR_WIDTH-1:0] new_base;

    assign new_row    = fetch_y >> BITS_PER_MEMORY_PIXEL_Y;
    assign new_row_ok = 32'(new_row) < ROWS;
    assign new_base   = ADDR_WIDTH'(RAM_SCREEN_OFFSET + 32'(new_row) * WORDS_PER_ROW);

    // pend_q tracks which issued addresses still have data in flight; stage
    // RAM_LATENCY-1 lines up with rdata_screen for that address.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            row_valid_q <= 1'b0;
            mode_smp_q  <= 1'b0;
            hex_q       <= 1'b0;
            overrun_q   <= 1'b0;
            idx_q       <= '0;
            drain_q     <= '0;
            pend_q      <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pend_idx_q[i] <= '0;
            end
            for (int i = 0; i < WORDS_PER_ROW; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            for (int i = RAM_LATENCY - 1; i > 0; i--) begin
                pend_q[i]     <= pend_q[i-1];
                pend_idx_q[i] <= pend_idx_q[i-1];
            end
            pend_q[0]     <= (state_q == StFetch);
            pend_idx_q[0] <= idx_q;

            if (pend_q[RAM_LATENCY-1] && !line_start) begin
                line_q[pend_idx_q[RAM_LATENCY-1]] <= rdata_screen;
            end

            if (line_start) begin
                // A new line always invalidates the buffer; an unfinished fetch is dropped.
                if (state_q != StIdle) begin
                    overrun_q <= 1'b1;
                end
                row_valid_q <= 1'b0;
                mode_smp_q  <= mode;
                pend_q      <= '0;
                if (new_row_ok) begin
                    state_q <= StFetch;
                    busy_q  <= 1'b1;
                    addr_q  <= new_base;
                    idx_q   <= '0;
                end else begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StFetch: begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= StDrain;
                            drain_q <= '0;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                    StDrain: begin
                        if (drain_q == LAST_DRAIN) begin
                            state_q     <= StIdle;
                            busy_q      <= 1'b0;
                            row_valid_q <= 1'b1;
                            hex_q       <= mode_smp_q;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [31:0]          bin_idx;
    logic [31:0]          hex_idx;
    logic [31:0]          word_idx;
    logic [31:0]          bit_pos;
    logic [31:0]          nib_pos;
    logic [RAM_WIDTH-1:0] sel_word;
    logic                 in_range;
    logic                 valid_d;
    logic                 bit_d;
    logic [3:0]           nib_d;

    // Leftmost cell shows the most significant bit / nibble of each word.
    always_comb begin
        bin_idx  = 32'(pixel_x) >> BITS_PER_MEMORY_PIXEL_X;
        hex_idx  = 32'(pixel_x) / PIXELS_PER_HEX_DIGIT;
        word_idx = hex_q ? hex_idx / NIBS_PER_WORD : bin_idx / RAM_WIDTH;
        bit_pos  = RAM_WIDTH - 1 - bin_idx % RAM_WIDTH;
        nib_pos  = NIBS_PER_WORD - 1 - hex_idx % NIBS_PER_WORD;
        in_range = word_idx < WORDS_PER_ROW;
        sel_word = '0;
        for (int i = 0; i < WORDS_PER_ROW; i++) begin
            if (word_idx == 32'(i)) begin
                sel_word = line_q[i];
            end
        end
        valid_d = display_en & row_valid_q & ~busy_q & in_range;
        bit_d   = valid_d & ~hex_q & 1'(sel_word >> bit_pos);
        nib_d   = (valid_d & hex_q) ? 4'(sel_word >> (nib_pos * 4)) : 4'h0;
    end

    logic       cell_valid_q;
    logic       cell_bit_q;
    logic [3:0] cell_nibble_q;
    logic       cell_is_hex_q;

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            cell_valid_q  <= 1'b0;
            cell_bit_q    <= 1'b0;
            cell_nibble_q <= 4'h0;
            cell_is_hex_q <= 1'b0;
        end else begin
            cell_valid_q  <= valid_d;
            cell_bit_q    <= bit_d;
            cell_nibble_q <= nib_d;
            cell_is_hex_q <= hex_q;
        end
    end

    assign addr_screen = addr_q;
    assign fetch_busy  = busy_q;
    assign overrun     = overrun_q;
    assign cell_valid  = cell_valid_q;
    assign cell_bit    = cell_bit_q;
    assign cell_nibble = cell_nibble_q;
    assign cell_is_hex = cell_is_hex_q;

endmodule
